alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single registered ALU: round-robin grant, issue, wait with watchdog, respond.
// One operation in flight; accept-to-response is 3 cycles, and requesters only see READY while idle.
module alu_arbiter #(
  parameter int OPER_WIDTH = 8,
  parameter int OUT_WIDTH  = OPER_WIDTH * 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0_VALID,
  input  logic                  REQ1_VALID,
  output logic                  REQ0_READY,
  output logic                  REQ1_READY,
  input  logic [OPER_WIDTH-1:0] REQ0_A,
  input  logic [OPER_WIDTH-1:0] REQ0_B,
  input  logic [OPER_WIDTH-1:0] REQ1_A,
  input  logic [OPER_WIDTH-1:0] REQ1_B,
  input  logic [3:0]            REQ0_FUN,
  input  logic [3:0]            REQ1_FUN,
  output logic [OPER_WIDTH-1:0] ALU_A,
  output logic [OPER_WIDTH-1:0] ALU_B,
  output logic [3:0]            ALU_FUN,
  output logic                  ALU_EN,
  input  logic [OUT_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VALID,
  output logic                  RSP_VALID,
  output logic                  RSP_ID,
  output logic [OUT_WIDTH-1:0]  RSP_DATA,
  output logic                  RSP_ERR,
  input  logic                  RSP_READY,
  output logic                  BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t     state;
  logic       pri;
  logic [2:0] wd;
  logic       idle;
  logic       gnt0;
  logic       gnt1;

  // Gating with RST keeps READY low while reset is held, even though state already reads IDLE.
  assign idle       = (state == S_IDLE) && RST;
  assign gnt0       = idle && REQ0_VALID && (!REQ1_VALID || !pri);
  assign gnt1       = idle && REQ1_VALID && (!REQ0_VALID || pri);
  assign REQ0_READY = gnt0;
  assign REQ1_READY = gnt1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      pri       <= 1'b0;
      wd        <= 3'd0;
      ALU_A     <= '0;
      ALU_B     <= '0;
      ALU_FUN   <= 4'd0;
      ALU_EN    <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_ID    <= 1'b0;
      RSP_DATA  <= '0;
      RSP_ERR   <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt0 || gnt1) begin
            ALU_A   <= gnt1 ? REQ1_A   : REQ0_A;
            ALU_B   <= gnt1 ? REQ1_B   : REQ0_B;
            ALU_FUN <= gnt1 ? REQ1_FUN : REQ0_FUN;
            RSP_ID  <= gnt1;
            ALU_EN  <= 1'b1;
            BUSY    <= 1'b1;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          ALU_EN <= 1'b0;
          wd     <= 3'd0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (ALU_OUT_VALID) begin
            RSP_DATA  <= ALU_OUT;
            RSP_ERR   <= 1'b0;
            RSP_VALID <= 1'b1;
            state     <= S_RESP;
          end else if (wd == 3'd3) begin
            // Fourth silent WAIT cycle: give up and report a timeout.
            RSP_DATA  <= '0;
            RSP_ERR   <= 1'b1;
            RSP_VALID <= 1'b1;
            state     <= S_RESP;
          end else begin
            wd <= wd + 3'd1;
          end
        end
        S_RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            BUSY      <= 1'b0;
            pri       <= ~RSP_ID;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
